nr_div_seq_ctrl: RTL and testbench



---
 rtl/nr_div_seq_ctrl.sv | 118 +++++++++++
 tb/tb_nr_div_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nr_div_seq_ctrl.sv
// Sequential non-restoring unsigned divider: one add/subtract-and-shift step per clock,
// then a remainder correction cycle. Optional abort input enabled by NRDIV_ABORT_EN.
module nr_div_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
`ifdef NRDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH:0]   R
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        CORR
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a, m, a_shift, a_step;
    logic [WIDTH-1:0] qs;
    logic [CW-1:0]    cnt;
    logic             y_zero;
    logic             abort_hit;

    assign y_zero = (Y == '0);
    assign busy   = (state != IDLE);

`ifdef NRDIV_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // The sign of the partial remainder before the step picks subtract or add.
    always_comb begin
        a_shift = {a[WIDTH-1:0], qs[WIDTH-1]};
        a_step  = a[WIDTH] ? (a_shift + m) : (a_shift - m);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !y_zero) state_nxt = ITER;
            ITER:    if (cnt == CW'(1)) state_nxt = CORR;
            CORR:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            qs   <= '0;
            m    <= '0;
            cnt  <= '0;
            Q    <= '0;
            R    <= '0;
            dbz  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                a   <= '0;
                qs  <= '0;
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !y_zero) begin
                            a   <= '0;
                            qs  <= X;
                            m   <= {1'b0, Y};
                            cnt <= CW'(WIDTH);
                        end else if (start) begin
                            Q    <= '1;
                            R    <= {1'b0, X};
                            dbz  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                    ITER: begin
                        a   <= a_step;
                        qs  <= {qs[WIDTH-2:0], ~a_step[WIDTH]};
                        cnt <= cnt - CW'(1);
                    end
                    CORR: begin
                        // A negative final partial remainder is restored by adding M back.
                        R    <= a[WIDTH] ? (a + m) : a;
                        Q    <= qs;
                        dbz  <= 1'b0;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nr_div_seq_ctrl.sv
// Self-checking bench for nr_div_seq_ctrl: table-driven back-to-back divisions plus
// hand sequences for reset, ignored starts and (with NRDIV_ABORT_EN) abort.
module tb_nr_div_seq_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] X, Y;
    logic             abort;
    logic             busy, done, dbz;
    logic [WIDTH-1:0] Q;
    logic [WIDTH:0]   R;

    int n_chk = 0;
    int n_bad = 0;

    nr_div_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
`ifdef NRDIV_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .Q     (Q),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] q;
        logic [WIDTH:0]   r;
        logic             z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from an idle or done cycle and returns in the cycle done is seen.
    task automatic run_op(input vec_t v, input string name);
        logic [WIDTH-1:0] q_prev;
        logic [WIDTH:0]   r_prev;
        int lat, busy_cnt, held_bad;
        q_prev   = Q;
        r_prev   = R;
        start    = 1'b1;
        X        = v.x;
        Y        = v.y;
        step();
        start    = 1'b0;
        X        = ~v.x;
        Y        = ~v.y;
        lat      = 0;
        busy_cnt = 0;
        held_bad = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            if (Q !== q_prev || R !== r_prev) held_bad++;
            step();
            lat++;
        end
        check({name, " latency"}, lat, v.z ? 0 : WIDTH + 1);
        check({name, " busy cycles"}, busy_cnt, v.z ? 0 : WIDTH + 1);
        check({name, " held"}, held_bad, 0);
        check({name, " Q"}, Q, v.q);
        check({name, " R"}, R, v.r);
        check({name, " dbz"}, dbz, v.z);
    endtask

    vec_t tbl[10];

    initial begin
        int n_done;

        tbl[0] = '{x: 4'd6,  y: 4'd2,  q: 4'b0011, r: 5'b00000, z: 1'b0};
        tbl[1] = '{x: 4'd12, y: 4'd3,  q: 4'b0100, r: 5'b00000, z: 1'b0};
        tbl[2] = '{x: 4'd13, y: 4'd12, q: 4'b0001, r: 5'b00001, z: 1'b0};
        tbl[3] = '{x: 4'd5,  y: 4'd10, q: 4'b0000, r: 5'b00101, z: 1'b0};
        tbl[4] = '{x: 4'd9,  y: 4'd12, q: 4'b0000, r: 5'b01001, z: 1'b0};
        tbl[5] = '{x: 4'd14, y: 4'd9,  q: 4'b0001, r: 5'b00101, z: 1'b0};
        tbl[6] = '{x: 4'd13, y: 4'd0,  q: 4'b1111, r: 5'b01101, z: 1'b1};
        tbl[7] = '{x: 4'd1,  y: 4'd1,  q: 4'b0001, r: 5'b00000, z: 1'b0};
        tbl[8] = '{x: 4'd15, y: 4'd1,  q: 4'b1111, r: 5'b00000, z: 1'b0};
        tbl[9] = '{x: 4'd0,  y: 4'd5,  q: 4'b0000, r: 5'b00000, z: 1'b0};

        start = 1'b0;
        abort = 1'b0;
        X     = '0;
        Y     = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", dbz, 0);
        check("reset Q", Q, 0);
        check("reset R", R, 0);
        #20 rst_n = 1'b1;
        step();

        // Back-to-back: each operation starts in the done cycle of the previous one.
        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));
        step();
        check("done one cycle", done, 0);

        // Starts and operand changes while busy are ignored.
        start = 1'b1;
        X = 4'd7;
        Y = 4'd2;
        step();
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            start = (c < 3);
            X = 4'(c + 9);
            Y = 4'(c + 3);
            if (done) n_done++;
            step();
        end
        start = 1'b0;
        check("ignored start dones", n_done, 1);
        check("ignored start Q", Q, 4'b0011);
        check("ignored start R", R, 5'b00001);
        check("ignored start busy", busy, 0);

        // Reset asserted mid-ITER abandons the operation.
        start = 1'b1;
        X = 4'd15;
        Y = 4'd4;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset Q", Q, 0);
        check("midreset R", R, 0);
        #8 rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            step();
        end
        check("midreset no done", n_done, 0);
        run_op('{x: 4'd15, y: 4'd4, q: 4'b0011, r: 5'b00011, z: 1'b0}, "after reset");

`ifdef NRDIV_ABORT_EN
        run_op('{x: 4'd14, y: 4'd9, q: 4'b0001, r: 5'b00101, z: 1'b0}, "pre abort");
        step();
        start = 1'b1;
        X = 4'd7;
        Y = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", busy, 0);
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            step();
        end
        check("abort no done", n_done, 0);
        check("abort Q held", Q, 4'b0001);
        check("abort R held", R, 5'b00101);
        run_op('{x: 4'd7, y: 4'd2, q: 4'b0011, r: 5'b00001, z: 1'b0}, "after abort");
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
